hex_scroll_ctrl: RTL and testbench

- Controller for the six DE-series HEX displays.
- Loads a message of hex digits one at a time from SW[3:0] using KEY pushbuttons, stores up to DEPTH digits, and scrolls the message across HEX5..HEX0 at a programmable tick rate.
- Instantiated in the board top in place of a purely combinational switch-to-HEX path.

---
 rtl/hex_scroll_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// hex_scroll_ctrl : loads hex digits from switches and scrolls them on HEX5..0
// Revision: 1.0
// ============================================================================
module hex_scroll_ctrl #(
    parameter int TICK_DIV = 25000000,
    parameter int DEPTH    = 16
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] C_TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [LW-1:0] C_DEPTH    = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_EDIT   = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

    logic [1:0]    key_s1_q, key_s2_q, key_s3_q;
    logic [5:0]    sw_s1_q, sw_s2_q;
    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] start_q, start_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    msg_q [DEPTH];
    logic [3:0]    msg_d [DEPTH];
    logic [6:0]    hex_q [6];
    logic [6:0]    hex_d [6];
    logic [9:0]    ledr_q, ledr_d;

    logic          load_pulse, clr_pulse, run, dir;
    logic [3:0]    digit;
    logic [LW:0]   fwd_sum, rev_sum;
    logic [LW-1:0] fwd_start, rev_start;
    logic          unused_sw;

    assign unused_sw  = ^SW[7:4];
    assign load_pulse = key_s3_q[0] & ~key_s2_q[0];
    assign clr_pulse  = key_s3_q[1] & ~key_s2_q[1];
    assign digit      = sw_s2_q[3:0];
    assign dir        = sw_s2_q[4];
    assign run        = sw_s2_q[5];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    // start < len always holds, so one conditional subtract is a full modulo
    always_comb begin
        fwd_sum   = {1'b0, start_q} + (LW+1)'(1);
        rev_sum   = {1'b0, start_q} + {1'b0, len_q} - (LW+1)'(1);
        fwd_start = (fwd_sum >= {1'b0, len_q}) ? LW'(fwd_sum - {1'b0, len_q}) : LW'(fwd_sum);
        rev_start = (rev_sum >= {1'b0, len_q}) ? LW'(rev_sum - {1'b0, len_q}) : LW'(rev_sum);
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        start_d = start_q;
        tick_d  = tick_q;
        msg_d   = msg_q;
        if (clr_pulse) begin
            state_d = ST_EMPTY;
            len_d   = '0;
            start_d = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (load_pulse) begin
                        msg_d[0] = digit;
                        len_d    = LW'(1);
                        start_d  = '0;
                        tick_d   = '0;
                        state_d  = run ? ST_SCROLL : ST_EDIT;
                    end
                end
                ST_EDIT: begin
                    if (load_pulse && (len_q != C_DEPTH)) begin
                        msg_d[len_q[AW-1:0]] = digit;
                        len_d                = len_q + LW'(1);
                    end
                    if (run) begin
                        state_d = ST_SCROLL;
                        tick_d  = '0;
                    end
                end
                ST_SCROLL: begin
                    if (!run) begin
                        state_d = ST_EDIT;
                    end else if (tick_q == C_TICK_MAX) begin
                        tick_d  = '0;
                        start_d = dir ? rev_start : fwd_start;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            logic [LW:0] sum;
            sum = {1'b0, start_q} + (LW+1)'(i);
            if (sum >= {1'b0, len_q}) sum = sum - {1'b0, len_q};
            if (state_q == ST_EMPTY || (LW+1)'(i) >= {1'b0, len_q})
                hex_d[i] = 7'h7F;
            else
                hex_d[i] = seg7(msg_q[sum[AW-1:0]]);
        end
        ledr_d = {(len_q == C_DEPTH), (state_q == ST_SCROLL), 3'b000, 5'(len_q)};
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            key_s1_q <= 2'b11;
            key_s2_q <= 2'b11;
            key_s3_q <= 2'b11;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            state_q  <= ST_EMPTY;
            len_q    <= '0;
            start_q  <= '0;
            tick_q   <= '0;
            ledr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) msg_q[i] <= 4'h0;
            for (int i = 0; i < 6; i++)     hex_q[i] <= 7'h7F;
        end else begin
            key_s1_q <= KEY;
            key_s2_q <= key_s1_q;
            key_s3_q <= key_s2_q;
            sw_s1_q  <= {SW[9], SW[8], SW[3:0]};
            sw_s2_q  <= sw_s1_q;
            state_q  <= state_d;
            len_q    <= len_d;
            start_q  <= start_d;
            tick_q   <= tick_d;
            ledr_q   <= ledr_d;
            msg_q    <= msg_d;
            hex_q    <= hex_d;
        end
    end

    // position 0 is the leftmost display
    assign HEX5 = hex_q[0];
    assign HEX4 = hex_q[1];
    assign HEX3 = hex_q[2];
    assign HEX2 = hex_q[3];
    assign HEX1 = hex_q[4];
    assign HEX0 = hex_q[5];
    assign LEDR = ledr_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hex_scroll_ctrl : scoreboard bench for hex_scroll_ctrl (TICK_DIV=4)
// Revision: 1.0
// ============================================================================
module tb_hex_scroll_ctrl;

    logic       clk = 1'b0;
    logic       Reset;
    logic [1:0] KEY;
    logic [9:0] SW;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        bit         chk_hex;
        logic [41:0] hex;
        logic [9:0] ledr;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    always #5 clk = ~clk;

    hex_scroll_ctrl #(.TICK_DIV(4), .DEPTH(16)) dut (
        .CLOCK_50(clk), .Reset(Reset), .KEY(KEY), .SW(SW),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .HEX4(HEX4), .HEX5(HEX5), .LEDR(LEDR)
    );

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
        endcase
    endfunction

    // dig holds HEX5..HEX0 nibbles left to right; blank bit 5 is HEX5
    function automatic logic [41:0] win(input logic [23:0] dig, input logic [5:0] blank);
        logic [41:0] r;
        r = '0;
        for (int i = 0; i < 6; i++)
            r[41-7*i -: 7] = blank[5-i] ? 7'h7F : seg(dig[23-4*i -: 4]);
        return r;
    endfunction

    task automatic expect_disp(input string name, input logic [23:0] dig,
                               input logic [5:0] blank, input logic [9:0] ledr);
        exp_t e;
        e.name = name; e.chk_hex = 1'b1; e.hex = win(dig, blank); e.ledr = ledr;
        exp_q.push_back(e);
    endtask

    task automatic expect_ledr(input string name, input logic [9:0] ledr);
        exp_t e;
        e.name = name; e.chk_hex = 1'b0; e.hex = '0; e.ledr = ledr;
        exp_q.push_back(e);
    endtask

    // monitor: compares every queued expectation against the outputs at this falling edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            if (cur.chk_hex) begin
                total++;
                if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== cur.hex) begin
                    bad++;
                    $display("FAIL %s hex: got %h want %h", cur.name,
                             {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, cur.hex);
                end
            end
            total++;
            if (LEDR !== cur.ledr) begin
                bad++;
                $display("FAIL %s ledr: got %h want %h", cur.name, LEDR, cur.ledr);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; KEY = 2'b11; SW = '0;
        cycles(3);
        Reset = 1'b0;
        cycles(3);
    endtask

    task automatic load(input logic [3:0] d);
        SW[3:0] = d;
        cycles(3);
        KEY[0] = 1'b0;
        cycles(4);
        KEY[0] = 1'b1;
        cycles(4);
    endtask

    task automatic wait_scroll(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = LEDR[8];
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got LEDR[8]=0 want 1 within 50 cycles", name);
        end
    endtask

    initial begin
        do_reset();
        expect_disp("reset", 24'h000000, 6'b111111, 10'h000);
        cycles(2);

        // 1: partial message in EDIT
        load(4'h1); load(4'h2); load(4'h3);
        expect_disp("edit3", 24'h123000, 6'b000111, 10'h003);
        cycles(2);

        // 2: forward scroll of 0..7
        do_reset();
        for (int d = 0; d < 8; d++) load(4'(d));
        SW[9] = 1'b1;
        wait_scroll("fwd");
        expect_disp("fwd0", 24'h012345, 6'b000000, 10'h108);
        cycles(4);
        expect_disp("fwd1", 24'h123456, 6'b000000, 10'h108);
        cycles(4);
        expect_disp("fwd2", 24'h234567, 6'b000000, 10'h108);
        cycles(4);
        expect_disp("fwd3", 24'h345670, 6'b000000, 10'h108);
        cycles(2);

        // 3: reverse scroll then freeze
        do_reset();
        for (int d = 0; d < 8; d++) load(4'(d));
        SW[8] = 1'b1;
        cycles(3);
        SW[9] = 1'b1;
        wait_scroll("rev");
        expect_disp("rev0", 24'h012345, 6'b000000, 10'h108);
        cycles(4);
        expect_disp("rev1", 24'h701234, 6'b000000, 10'h108);
        SW[9] = 1'b0;
        cycles(10);
        expect_disp("freeze", 24'h701234, 6'b000000, 10'h008);
        cycles(2);

        // 4: saturation at DEPTH, 17th digit dropped, no load while scrolling
        do_reset();
        for (int d = 0; d < 16; d++) load(4'(d));
        load(4'h9);
        expect_disp("full", 24'h012345, 6'b000000, 10'h210);
        cycles(2);
        SW[9] = 1'b1;
        wait_scroll("full_scroll");
        load(4'h9);
        expect_ledr("scroll_load", 10'h310);
        cycles(2);

        // 5: clear beats a simultaneous load; single-digit scroll from EMPTY
        do_reset();
        load(4'hA); load(4'hB); load(4'hC); load(4'hD); load(4'hE);
        expect_disp("len5", 24'hABCDE0, 6'b000001, 10'h005);
        cycles(2);
        SW[3:0] = 4'h9;
        cycles(3);
        KEY = 2'b00;
        cycles(4);
        KEY = 2'b11;
        cycles(4);
        expect_disp("clr_wins", 24'h000000, 6'b111111, 10'h000);
        cycles(2);
        SW[9] = 1'b1;
        load(4'h7);
        expect_disp("len1_scroll", 24'h700000, 6'b011111, 10'h101);
        cycles(6);
        expect_disp("len1_hold", 24'h700000, 6'b011111, 10'h101);
        cycles(2);

        // 6: asynchronous reset mid-step
        do_reset();
        for (int d = 0; d < 8; d++) load(4'(d));
        SW[9] = 1'b1;
        wait_scroll("async");
        cycles(1);
        Reset = 1'b1;
        #1;
        expect_disp("async_rst", 24'h000000, 6'b111111, 10'h000);
        cycles(3);
        Reset = 1'b0;
        cycles(20);
        expect_disp("post_rst", 24'h000000, 6'b111111, 10'h000);
        cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
